// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, counter widths, bus mode and FSM encoding.
// Used by spi_master and its clock generator.
package spi_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);
  localparam int unsigned DIV_W     = 8;

  // Mode 0: CPOL=0, CPHA=0
  localparam logic [1:0] SPI_MODE  = 2'b00;
  localparam logic       SCLK_IDLE = SPI_MODE[1];

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: o_tick_c fires on the last of every CLK_DIV enabled cycles.
// The count restarts from zero whenever i_en is low.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk27m,
  input  logic rst,
  input  logic i_en,
  output logic o_tick_c
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == TERM);

  always_ff @(posedge clk27m) begin
    if (rst || !i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per frame, MSB first, with setup, hold and inter-frame gap phases
// each one SCLK half-period long.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk27m,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              busy,
  output logic [BYTE_W-1:0] rx_data,
  output logic              data_valid,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e           r_state,      w_state_nxt;
  logic [BYTE_W-1:0]    r_tx_sr,      w_tx_sr_nxt;
  logic [BYTE_W-1:0]    r_rx_sr,      w_rx_sr_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt,    w_bit_cnt_nxt;
  logic                 r_busy,       w_busy_nxt;
  logic [BYTE_W-1:0]    r_rx_data,    w_rx_data_nxt;
  logic                 r_data_valid, w_data_valid_nxt;
  logic                 r_sclk,       w_sclk_nxt;
  logic                 r_cs,         w_cs_nxt;
  logic                 r_mosi,       w_mosi_nxt;
  logic                 w_en;
  logic                 w_tick;

  assign w_en = (r_state != ST_IDLE);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk27m   (clk27m),
    .rst      (rst),
    .i_en     (w_en),
    .o_tick_c (w_tick)
  );

  always_ff @(posedge clk27m) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_bit_cnt    <= '0;
      r_busy       <= 1'b0;
      r_rx_data    <= '0;
      r_data_valid <= 1'b0;
      r_sclk       <= SCLK_IDLE;
      r_cs         <= 1'b1;
      r_mosi       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_sr      <= w_tx_sr_nxt;
      r_rx_sr      <= w_rx_sr_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_sclk       <= w_sclk_nxt;
      r_cs         <= w_cs_nxt;
      r_mosi       <= w_mosi_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tx_sr_nxt      = r_tx_sr;
    w_rx_sr_nxt      = r_rx_sr;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_busy_nxt       = r_busy;
    w_rx_data_nxt    = r_rx_data;
    w_data_valid_nxt = 1'b0;
    w_sclk_nxt       = r_sclk;
    w_cs_nxt         = r_cs;
    w_mosi_nxt       = r_mosi;

    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_nxt   = ST_SETUP;
          w_tx_sr_nxt   = tx_data;
          w_mosi_nxt    = tx_data[BYTE_W-1];
          w_bit_cnt_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_cs_nxt      = 1'b0;
        end
      end

      ST_SETUP: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
          w_sclk_nxt  = ~SCLK_IDLE;
          w_rx_sr_nxt = {r_rx_sr[BYTE_W-2:0], miso};
        end
      end

      // The first rising edge is issued on SETUP exit; the bit counter wraps on the 8th fall,
      // so a low phase seen with a zero count is the trailing half-period of the last bit.
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_sclk != SCLK_IDLE) begin
            w_sclk_nxt    = SCLK_IDLE;
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt != BIT_LAST) begin
              w_tx_sr_nxt = {r_tx_sr[BYTE_W-2:0], 1'b0};
              w_mosi_nxt  = r_tx_sr[BYTE_W-2];
            end
          end else if (r_bit_cnt == '0) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_sclk_nxt  = ~SCLK_IDLE;
            w_rx_sr_nxt = {r_rx_sr[BYTE_W-2:0], miso};
          end
        end
      end

      ST_HOLD: begin
        if (w_tick) begin
          w_state_nxt      = ST_GAP;
          w_cs_nxt         = 1'b1;
          w_rx_data_nxt    = r_rx_sr;
          w_data_valid_nxt = 1'b1;
        end
      end

      ST_GAP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy       = r_busy;
  assign rx_data    = r_rx_data;
  assign data_valid = r_data_valid;
  assign sclk       = r_sclk;
  assign cs         = r_cs;
  assign mosi       = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance for single frames and a CLK_DIV=2
// instance for back-to-back frames, with a small slave model on the bus.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] tx_data4 = 8'h00;
  logic       tx_start4 = 1'b0;
  logic       busy4, dv4, sclk4, cs4, mosi4, miso4;
  logic [7:0] rx4;

  logic [7:0] tx_data2 = 8'h00;
  logic       tx_start2 = 1'b0;
  logic       busy2, dv2, sclk2, cs2, mosi2;
  logic [7:0] rx2;

  // 0: loopback, 1: miso tied high, 2: slave model drives miso
  int         miso_mode = 0;

  int n_checks = 0;
  int n_errors = 0;

  // bus monitor state (written only by the monitor process)
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  int         cs_low_run = 0;
  int         last_cs_low = 0;
  logic       last_rise_dv = 1'b0;
  int         rise_cnt = 0;
  int         dv_cnt = 0;
  int         frames = 0;
  int         slave_frames = 0;
  int         mosi_hi_cnt = 0;
  logic [7:0] slave_sr = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic [7:0] slave_tx = 8'h00;

  always #5 clk = ~clk;

  assign miso4 = (miso_mode == 0) ? mosi4 :
                 (miso_mode == 1) ? 1'b1  : slave_tx[7];

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk27m     (clk),
    .rst        (rst),
    .tx_data    (tx_data4),
    .tx_start   (tx_start4),
    .busy       (busy4),
    .rx_data    (rx4),
    .data_valid (dv4),
    .sclk       (sclk4),
    .cs         (cs4),
    .mosi       (mosi4),
    .miso       (miso4)
  );

  spi_master #(.CLK_DIV(2)) dut2 (
    .clk27m     (clk),
    .rst        (rst),
    .tx_data    (tx_data2),
    .tx_start   (tx_start2),
    .busy       (busy2),
    .rx_data    (rx2),
    .data_valid (dv2),
    .sclk       (sclk2),
    .cs         (cs2),
    .mosi       (mosi2),
    .miso       (mosi2)
  );

  // Mode-0 slave model and frame statistics, sampled mid-cycle
  always @(negedge clk) begin
    prev_sclk <= sclk4;
    prev_cs   <= cs4;
    if (cs4 == 1'b0) begin
      cs_low_run <= cs_low_run + 1;
      if (mosi4 == 1'b1) mosi_hi_cnt <= mosi_hi_cnt + 1;
    end
    if (cs4 == 1'b1 && prev_cs == 1'b0) begin
      last_cs_low  <= cs_low_run;
      cs_low_run   <= 0;
      last_rise_dv <= dv4;
      slave_rx     <= slave_sr;
      slave_frames <= slave_frames + 1;
    end
    if (cs4 == 1'b0 && prev_cs == 1'b1) begin
      frames   <= frames + 1;
      slave_tx <= 8'hC3;
    end
    if (dv4 == 1'b1) dv_cnt <= dv_cnt + 1;
    if (sclk4 == 1'b1 && prev_sclk == 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      slave_sr <= {slave_sr[6:0], mosi4};
    end
    if (sclk4 == 1'b0 && prev_sclk == 1'b1) slave_tx <= {slave_tx[6:0], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle4(input string tag);
    int n;
    n = 0;
    while (busy4 !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(busy4), 32'd0);
  endtask

  task automatic start4(input logic [7:0] d);
    tx_data4  = d;
    tx_start4 = 1'b1;
    tick();
    tx_start4 = 1'b0;
  endtask

  int         b_dv, b_rise, b_frames, b_mosi, b_slave;
  int         nf, f1, f2, low1, low2, gap, n;
  logic       p2;
  logic [7:0] rx_a, rx_b;

  initial begin
    // Reset, with tx_start asserted alongside rst
    tx_start4 = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_cs",   32'(cs4),   32'd1);
    check("rst_sclk", 32'(sclk4), 32'd0);
    check("rst_mosi", 32'(mosi4), 32'd0);
    check("rst_rx",   32'(rx4),   32'h00);
    check("rst_dv",   32'(dv4),   32'd0);
    rst       = 1'b0;
    tx_start4 = 1'b0;
    tick();
    check("start_during_rst_ignored", 32'(busy4), 32'd0);

    // Loopback 0xA5
    b_dv = dv_cnt; b_rise = rise_cnt;
    start4(8'hA5);
    check("a5_busy",  32'(busy4), 32'd1);
    check("a5_cs",    32'(cs4),   32'd0);
    check("a5_mosi0", 32'(mosi4), 32'd1);
    check("a5_sclk0", 32'(sclk4), 32'd0);
    repeat (12) tick();
    check("a5_rx_stable_in_shift", 32'(rx4), 32'h00);
    wait_idle4("a5_done");
    check("a5_rx",       32'(rx4),               32'hA5);
    check("a5_dv_cnt",   32'(dv_cnt - b_dv),     32'd1);
    check("a5_dv_at_cs", 32'(last_rise_dv),      32'd1);
    check("a5_cs_low",   32'(last_cs_low),       32'd72);
    check("a5_rises",    32'(rise_cnt - b_rise), 32'd8);
    check("a5_mosi_bus", 32'(slave_rx),          32'hA5);

    // miso high, tx 0x00
    miso_mode = 1;
    b_rise = rise_cnt; b_mosi = mosi_hi_cnt;
    start4(8'h00);
    wait_idle4("ff_done");
    check("ff_rx",      32'(rx4),                  32'hFF);
    check("ff_mosi_lo", 32'(mosi_hi_cnt - b_mosi), 32'd0);
    check("ff_rises",   32'(rise_cnt - b_rise),    32'd8);

    // Second request during SHIFT must be dropped
    miso_mode = 0;
    b_frames = frames;
    start4(8'h3C);
    repeat (20) tick();
    tx_data4  = 8'hFF;
    tx_start4 = 1'b1;
    repeat (10) tick();
    check("3c_busy_mid", 32'(busy4), 32'd1);
    tx_start4 = 1'b0;
    wait_idle4("3c_done");
    repeat (6) tick();
    check("3c_no_requeue", 32'(busy4),             32'd0);
    check("3c_frames",     32'(frames - b_frames), 32'd1);
    check("3c_mosi_bus",   32'(slave_rx),          32'h3C);
    check("3c_rx",         32'(rx4),               32'h3C);

    // Abort after the 3rd rising edge
    b_rise = rise_cnt;
    start4(8'hF0);
    n = 0;
    while (rise_cnt - b_rise < 3 && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach_3rd_rise", 32'(rise_cnt - b_rise >= 3), 32'd1);
    b_dv = dv_cnt;
    rst = 1'b1;
    tick();
    check("abort_cs",   32'(cs4),   32'd1);
    check("abort_sclk", 32'(sclk4), 32'd0);
    check("abort_rx",   32'(rx4),   32'h00);
    check("abort_dv",   32'(dv4),   32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("abort_no_dv", 32'(dv_cnt - b_dv), 32'd0);
    start4(8'h81);
    wait_idle4("81_done");
    check("81_rx",     32'(rx4),         32'h81);
    check("81_cs_low", 32'(last_cs_low), 32'd72);

    // Slave model: master sends 0x5A, slave returns 0xC3
    miso_mode = 2;
    b_slave = slave_frames;
    start4(8'h5A);
    wait_idle4("slv_done");
    check("slv_rx",    32'(slave_rx),               32'h5A);
    check("slv_frame", 32'(slave_frames - b_slave), 32'd1);
    check("slv_m_rx",  32'(rx4),                    32'hC3);
    miso_mode = 0;

    // Back-to-back frames at CLK_DIV=2 with tx_start held
    tx_data2 = 8'h12; tx_start2 = 1'b1;
    nf = 0; f1 = 0; f2 = 0; low1 = 0; low2 = 0; gap = 0; p2 = cs2;
    rx_a = 8'h00; rx_b = 8'h00;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (p2 == 1'b1 && cs2 == 1'b0) begin
        if (nf == 0) begin
          f1 = c;
          tx_data2 = 8'h34;
        end else begin
          f2 = c;
          tx_start2 = 1'b0;
        end
        nf++;
      end
      if (cs2 == 1'b0) begin
        if (nf == 1) low1++;
        else low2++;
      end else if (nf == 1) begin
        gap++;
      end
      if (p2 == 1'b0 && cs2 == 1'b1) begin
        if (nf == 1) rx_a = rx2;
        else rx_b = rx2;
      end
      p2 = cs2;
      if (nf == 2 && busy2 == 1'b0) break;
    end
    tx_start2 = 1'b0;
    check("b2b_frames",  32'(nf),        32'd2);
    check("b2b_period",  32'(f2 - f1),   32'd39);
    check("b2b_low1",    32'(low1),      32'd36);
    check("b2b_low2",    32'(low2),      32'd36);
    check("b2b_gap_min", 32'(gap >= 2),  32'd1);
    check("b2b_rx1",     32'(rx_a),      32'h12);
    check("b2b_rx2",     32'(rx_b),      32'h34);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
